// File: rtl/hazard_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : hazard_scheduler_if
// Purpose  : Pipeline status in, stall/flush/forward controls out.
// Revision : 1.0
// ============================================================================
interface hazard_scheduler_if #(
  parameter int CNT_W = 8
);
  logic             id_valid;
  logic [2:0]       id_srcA;
  logic [2:0]       id_srcB;
  logic             id_useA;
  logic             id_useB;
  logic             ex_valid;
  logic [2:0]       ex_dest;
  logic             ex_regWE;
  logic             ex_is_load;
  logic             ex_branch_taken;
  logic             mem_valid;
  logic [2:0]       mem_dest;
  logic             mem_regWE;
  logic             cnt_clr;
  logic             stall_if;
  logic             stall_id;
  logic             flush_if_id;
  logic             flush_id_ex;
  logic [1:0]       fwdA_sel;
  logic [1:0]       fwdB_sel;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_valid, id_srcA, id_srcB, id_useA, id_useB,
    output ex_valid, ex_dest, ex_regWE, ex_is_load, ex_branch_taken,
    output mem_valid, mem_dest, mem_regWE, cnt_clr,
    input  stall_if, stall_id, flush_if_id, flush_id_ex,
    input  fwdA_sel, fwdB_sel, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_valid, id_srcA, id_srcB, id_useA, id_useB,
    input  ex_valid, ex_dest, ex_regWE, ex_is_load, ex_branch_taken,
    input  mem_valid, mem_dest, mem_regWE, cnt_clr,
    output stall_if, stall_id, flush_if_id, flush_id_ex,
    output fwdA_sel, fwdB_sel, stall_cnt, flush_cnt
  );
endinterface
`default_nettype wire

// File: rtl/hazard_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : hazard_scheduler
// Purpose  : Load-use stall, taken-branch flush and operand forwarding control.
// Revision : 1.0
// ============================================================================
module hazard_scheduler #(
  parameter int LOAD_LAT  = 2,
  parameter int FLUSH_CYC = 2,
  parameter int CNT_W     = 8
) (
  input wire               clk,
  input wire               rst,
  hazard_scheduler_if.slave hs
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  localparam logic [2:0]       c_STALL_RELOAD = 3'(LOAD_LAT - 1);
  localparam logic [2:0]       c_FLUSH_RELOAD = 3'(FLUSH_CYC - 1);
  localparam logic [CNT_W-1:0] c_CNT_ONE      = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           r_state;
  state_t           w_state_nxt;
  logic [2:0]       r_cnt;
  logic [2:0]       w_cnt_nxt;
  logic             w_hazard;
  logic             w_stall;
  logic             w_flush_if_id;
  logic             w_flush_id_ex;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  assign w_hazard = hs.id_valid & hs.ex_valid & hs.ex_regWE & hs.ex_is_load &
                    ((hs.id_useA & (hs.ex_dest == hs.id_srcA)) |
                     (hs.id_useB & (hs.ex_dest == hs.id_srcB)));

  // EX result wins over EX/MEM; a load in EX has no result yet, so it never forwards.
  function automatic logic [1:0] fwd_sel(input logic use_src, input logic [2:0] src);
    logic [1:0] sel;
    sel = 2'b00;
    if (use_src) begin
      if (hs.ex_valid && hs.ex_regWE && !hs.ex_is_load && (hs.ex_dest == src))
        sel = 2'b01;
      else if (hs.mem_valid && hs.mem_regWE && (hs.mem_dest == src))
        sel = 2'b10;
    end
    return sel;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_RUN;
      r_cnt   <= 3'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_stall       = 1'b0;
    w_flush_if_id = 1'b0;
    w_flush_id_ex = 1'b0;
    if (hs.ex_branch_taken) begin
      // A taken branch overrides any hazard or stall in progress.
      w_flush_if_id = 1'b1;
      w_flush_id_ex = 1'b1;
      if (FLUSH_CYC == 1) begin
        w_state_nxt = ST_RUN;
        w_cnt_nxt   = 3'd0;
      end else begin
        w_state_nxt = ST_FLUSH;
        w_cnt_nxt   = c_FLUSH_RELOAD;
      end
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_hazard) begin
            w_stall       = 1'b1;
            w_flush_id_ex = 1'b1;
            if (LOAD_LAT == 1) begin
              w_state_nxt = ST_RUN;
              w_cnt_nxt   = 3'd0;
            end else begin
              w_state_nxt = ST_STALL;
              w_cnt_nxt   = c_STALL_RELOAD;
            end
          end
        end
        ST_STALL: begin
          w_stall       = 1'b1;
          w_flush_id_ex = 1'b1;
          if (r_cnt <= 3'd1) begin
            w_state_nxt = ST_RUN;
            w_cnt_nxt   = 3'd0;
          end else begin
            w_cnt_nxt = r_cnt - 3'd1;
          end
        end
        ST_FLUSH: begin
          w_flush_if_id = 1'b1;
          w_flush_id_ex = 1'b1;
          if (r_cnt <= 3'd1) begin
            w_state_nxt = ST_RUN;
            w_cnt_nxt   = 3'd0;
          end else begin
            w_cnt_nxt = r_cnt - 3'd1;
          end
        end
        default: begin
          w_state_nxt = ST_RUN;
          w_cnt_nxt   = 3'd0;
        end
      endcase
    end
  end

  // Clear beats increment; both counters stick at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else if (hs.cnt_clr) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + c_CNT_ONE;
      if (hs.ex_branch_taken && (r_flush_cnt != '1))
        r_flush_cnt <= r_flush_cnt + c_CNT_ONE;
    end
  end

  // Reset silences every control output immediately, not just at the next edge.
  assign hs.stall_if    = ~rst & w_stall;
  assign hs.stall_id    = ~rst & w_stall;
  assign hs.flush_if_id = ~rst & w_flush_if_id;
  assign hs.flush_id_ex = ~rst & w_flush_id_ex;
  assign hs.fwdA_sel    = rst ? 2'b00 : fwd_sel(hs.id_useA, hs.id_srcA);
  assign hs.fwdB_sel    = rst ? 2'b00 : fwd_sel(hs.id_useB, hs.id_srcB);
  assign hs.stall_cnt   = r_stall_cnt;
  assign hs.flush_cnt   = r_flush_cnt;

endmodule
`default_nettype wire

// File: tb/tb_hazard_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_scheduler
// Purpose  : Directed and random stimulus against a cycle-count reference model.
// Revision : 1.0
// ============================================================================
module tb_hazard_scheduler;
  localparam int LOAD_LAT  = 2;
  localparam int FLUSH_CYC = 2;
  localparam int CNT_W     = 8;
  localparam int CNT_MAX   = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_scheduler_if #(.CNT_W(CNT_W)) hs ();

  hazard_scheduler #(
    .LOAD_LAT (LOAD_LAT),
    .FLUSH_CYC(FLUSH_CYC),
    .CNT_W    (CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .hs (hs.slave)
  );

  int total = 0;
  int bad   = 0;
  // Model: cycles still owed to a stall or flush sequence, plus event tallies.
  int stall_rem = 0;
  int flush_rem = 0;
  int m_stall_cnt = 0;
  int m_flush_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int ref_fwd(input bit use_src, input int src);
    if (!use_src) return 0;
    if (hs.ex_valid && hs.ex_regWE && !hs.ex_is_load && int'(hs.ex_dest) == src) return 1;
    if (hs.mem_valid && hs.mem_regWE && int'(hs.mem_dest) == src) return 2;
    return 0;
  endfunction

  function automatic bit ref_hazard();
    bit a, b;
    a = hs.id_useA && (hs.ex_dest == hs.id_srcA);
    b = hs.id_useB && (hs.ex_dest == hs.id_srcB);
    return hs.id_valid && hs.ex_valid && hs.ex_regWE && hs.ex_is_load && (a || b);
  endfunction

  // Inputs are already applied; check this cycle, then advance through one edge.
  task automatic step();
    bit haz, br, e_stall, e_fif, e_fie;
    int fa, fb;
    #1;
    haz = ref_hazard();
    br  = hs.ex_branch_taken;
    e_stall = 0; e_fif = 0; e_fie = 0; fa = 0; fb = 0;
    if (rst) begin
      stall_rem = 0; flush_rem = 0; m_stall_cnt = 0; m_flush_cnt = 0;
    end else begin
      fa = ref_fwd(hs.id_useA, int'(hs.id_srcA));
      fb = ref_fwd(hs.id_useB, int'(hs.id_srcB));
      if (br) begin
        e_fif = 1; e_fie = 1;
      end else if (flush_rem > 0) begin
        e_fif = 1; e_fie = 1;
      end else if (stall_rem > 0 || haz) begin
        e_stall = 1; e_fie = 1;
      end
    end
    check("stall_if",    32'(hs.stall_if),    32'(e_stall));
    check("stall_id",    32'(hs.stall_id),    32'(e_stall));
    check("flush_if_id", 32'(hs.flush_if_id), 32'(e_fif));
    check("flush_id_ex", 32'(hs.flush_id_ex), 32'(e_fie));
    check("fwdA_sel",    32'(hs.fwdA_sel),    32'(fa));
    check("fwdB_sel",    32'(hs.fwdB_sel),    32'(fb));
    check("stall_cnt",   32'(hs.stall_cnt),   32'(m_stall_cnt));
    check("flush_cnt",   32'(hs.flush_cnt),   32'(m_flush_cnt));
    @(posedge clk);
    if (!rst) begin
      if (br) begin
        flush_rem = FLUSH_CYC - 1; stall_rem = 0;
      end else if (flush_rem > 0) begin
        flush_rem--;
      end else if (stall_rem > 0) begin
        stall_rem--;
      end else if (haz) begin
        stall_rem = LOAD_LAT - 1;
      end
      if (hs.cnt_clr) begin
        m_stall_cnt = 0; m_flush_cnt = 0;
      end else begin
        if (e_stall && m_stall_cnt < CNT_MAX) m_stall_cnt++;
        if (br && m_flush_cnt < CNT_MAX) m_flush_cnt++;
      end
    end
    #1;
  endtask

  task automatic idle_inputs();
    hs.id_valid = 0; hs.id_srcA = 0; hs.id_srcB = 0; hs.id_useA = 0; hs.id_useB = 0;
    hs.ex_valid = 0; hs.ex_dest = 0; hs.ex_regWE = 0; hs.ex_is_load = 0;
    hs.ex_branch_taken = 0; hs.mem_valid = 0; hs.mem_dest = 0; hs.mem_regWE = 0;
    hs.cnt_clr = 0;
  endtask

  task automatic load_use_r3();
    hs.ex_valid = 1; hs.ex_regWE = 1; hs.ex_is_load = 1; hs.ex_dest = 3'd3;
    hs.id_valid = 1; hs.id_srcA = 3'd3; hs.id_useA = 1;
  endtask

  task automatic rand_inputs();
    hs.id_valid   = 1'($urandom_range(0, 3) != 0);
    hs.id_srcA    = 3'($urandom_range(0, 3));
    hs.id_srcB    = 3'($urandom_range(0, 3));
    hs.id_useA    = 1'($urandom_range(0, 1));
    hs.id_useB    = 1'($urandom_range(0, 1));
    hs.ex_valid   = 1'($urandom_range(0, 3) != 0);
    hs.ex_dest    = 3'($urandom_range(0, 3));
    hs.ex_regWE   = 1'($urandom_range(0, 1));
    hs.ex_is_load = 1'($urandom_range(0, 1));
    hs.ex_branch_taken = 1'($urandom_range(0, 7) == 0);
    hs.mem_valid  = 1'($urandom_range(0, 1));
    hs.mem_dest   = 3'($urandom_range(0, 3));
    hs.mem_regWE  = 1'($urandom_range(0, 1));
    hs.cnt_clr    = 1'($urandom_range(0, 63) == 0);
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    // Reset must mask hazard and branch terms entirely.
    step();
    load_use_r3();
    hs.ex_branch_taken = 1;
    step();
    idle_inputs();
    rst = 1'b0;
    step();

    // Load-use stall lasts LOAD_LAT cycles.
    load_use_r3();
    step();
    step();
    idle_inputs();
    step();
    check("loaduse_stall_cnt", 32'(hs.stall_cnt), 32'(LOAD_LAT));

    // EX beats MEM; without EX write enable MEM forwards.
    hs.ex_valid = 1; hs.ex_regWE = 1; hs.ex_dest = 3'd5;
    hs.mem_valid = 1; hs.mem_regWE = 1; hs.mem_dest = 3'd5;
    hs.id_valid = 1; hs.id_srcB = 3'd5; hs.id_useB = 1;
    #1 check("fwdB_ex", 32'(hs.fwdB_sel), 32'd1);
    step();
    hs.ex_regWE = 0;
    #1 check("fwdB_mem", 32'(hs.fwdB_sel), 32'd2);
    step();
    hs.id_useB = 0;
    step();
    idle_inputs();

    // Branch in the first stall cycle overrides the stall.
    load_use_r3();
    step();
    hs.ex_branch_taken = 1;
    #1 check("br_in_stall", 32'(hs.stall_id), 32'd0);
    step();
    idle_inputs();
    step();
    step();
    check("br_flush_cnt", 32'(hs.flush_cnt), 32'd1);

    // Reset mid-flush; hazard right after release must stall.
    hs.ex_branch_taken = 1;
    step();
    hs.ex_branch_taken = 0;
    rst = 1'b1;
    #1 check("rst_flush", 32'(hs.flush_if_id), 32'd0);
    step();
    rst = 1'b0;
    step();
    load_use_r3();
    #1 check("post_rst_stall", 32'(hs.stall_id), 32'd1);
    step();
    idle_inputs();
    step();
    step();

    // Qualifiers: no id_valid, or no source used.
    load_use_r3();
    hs.id_valid = 0;
    step();
    hs.id_valid = 1; hs.id_useA = 0; hs.id_useB = 0;
    step();
    idle_inputs();

    // Saturation, then clear racing a stall.
    hs.cnt_clr = 1;
    step();
    hs.cnt_clr = 0;
    load_use_r3();
    for (int i = 0; i < CNT_MAX + 3; i++) step();
    check("stall_sat", 32'(hs.stall_cnt), 32'(CNT_MAX));
    hs.cnt_clr = 1;
    step();
    check("clr_beats_inc", 32'(hs.stall_cnt), 32'd0);
    idle_inputs();
    step();

    for (int i = 0; i < 1500; i++) begin
      rand_inputs();
      rst = 1'($urandom_range(0, 199) == 0);
      step();
    end
    rst = 1'b0;
    idle_inputs();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
